// File: rtl/uart_tx_console_pkg.sv
// Shared definitions for the console serial transmitter: FSM states, frame sizes, baud default.
// Frame length depends on UART_TX_PARITY_EN (8E1 when defined, 8N1 otherwise).
package uart_tx_console_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int DATA_BITS       = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS      = 11;
`else
  localparam int FRAME_BITS      = 10;
`endif
  localparam int DEFAULT_CLK_DIV = 5208;
  localparam int BAUD_W          = 16;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_console_fifo.sv
// Small character FIFO for the console transmitter; show-ahead read, registered full/empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    next_count;
  logic             push;
  logic             pop;

  // Full/empty are registered, so a push while full is refused even if a pop happens that edge.
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    next_count = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= next_count;
      full  <= (next_count == CW'(DEPTH));
      empty <= (next_count == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_console.sv
// Console serial transmitter: FIFO-buffered 8N1 (8E1 with UART_TX_PARITY_EN) frames on txd,
// plus a KL8-style printer flag raised at the end of every stop bit.
module uart_tx_console
  import uart_tx_console_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       flag,
  input  logic       flag_clr,
  output logic       busy,
  output logic       txd
);

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);

  tx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [7:0]        fifo_rdata;
  logic              bit_done;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_valid),
    .wr_data (wr_data),
    .full    (fifo_full),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty)
  );

  assign bit_done = (baud_cnt == '0);
  assign fifo_pop = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_done));
  assign wr_ready = ~fifo_full;
  assign busy     = (state != ST_IDLE) | ~fifo_empty;

  // txd is registered from the current state, so the line trails the FSM by one clock.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
      flag     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if ((state == ST_STOP) && bit_done) flag <= 1'b1;
      else if (flag_clr)                  flag <= 1'b0;

      if ((state != ST_IDLE) && !bit_done) baud_cnt <= baud_cnt - 1'b1;

      case (state)
        ST_IDLE: begin
          txd <= 1'b1;
          if (!fifo_empty) begin
            shift    <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
            parity_bit <= even_parity(fifo_rdata);
`endif
            baud_cnt <= BAUD_RELOAD;
            state    <= ST_START;
          end
        end
        ST_START: begin
          txd <= 1'b0;
          if (bit_done) begin
            baud_cnt <= BAUD_RELOAD;
            bit_cnt  <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          txd <= shift[0];
          if (bit_done) begin
            shift    <= shift >> 1;
            baud_cnt <= BAUD_RELOAD;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          txd <= parity_bit;
          if (bit_done) begin
            baud_cnt <= BAUD_RELOAD;
            state    <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          txd <= 1'b1;
          // A queued character starts its start bit with no idle gap.
          if (bit_done) begin
            baud_cnt <= BAUD_RELOAD;
            if (!fifo_empty) begin
              shift <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
              parity_bit <= even_parity(fifo_rdata);
`endif
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_console.sv
// Self-checking bench for uart_tx_console (CLK_DIV=4): waveform model, mid-bit line sampler,
// randomized traffic. Honours UART_TX_PARITY_EN for the expected frame length.
module tb_uart_tx_console;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       reset_n;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       flag;
  logic       flag_clr;
  logic       busy;
  logic       txd;

  int vectors;
  int miscompares;

  logic [7:0] rx_q[$];

  uart_tx_console #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .flag     (flag),
    .flag_clr (flag_clr),
    .busy     (busy),
    .txd      (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for bit idx of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == NB - 1) return 1'b1;
    return ($countones(b) % 2) == 1;
  endfunction

  // Line sampler: finds a start edge, samples every bit at its middle, decodes the byte.
  bit         mon_busy;
  int         mon_cnt;
  int         mon_k;
  logic [7:0] mon_byte;

  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (txd === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
      end
    end else begin
      mon_cnt++;
    end
    if (mon_busy && reset_n === 1'b1 && (mon_cnt % DIV) == DIV / 2) begin
      mon_k = mon_cnt / DIV;
      if (mon_k == 0) begin
        vectors++;
        if (txd !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL mon_start: txd=%b required 0 at %0t", txd, $time);
        end
      end else if (mon_k <= 8) begin
        mon_byte[mon_k-1] = txd;
      end else if (mon_k < NB - 1) begin
        vectors++;
        if (txd !== (($countones(mon_byte) % 2) == 1)) begin
          miscompares++;
          $display("[TB] FAIL mon_parity: txd=%b for byte %h at %0t", txd, mon_byte, $time);
        end
      end else begin
        vectors++;
        if (txd !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL mon_stop: txd=%b required 1 at %0t", txd, $time);
        end
        rx_q.push_back(mon_byte);
        mon_busy = 1'b0;
      end
    end
  end

  task automatic write_byte(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wr_data  = 8'($urandom);
  endtask

  task automatic clear_flag();
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors += 4;
    if (txd !== 1'b1)      begin miscompares++; $display("[TB] FAIL reset_txd: got %b want 1", txd); end
    if (wr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", wr_ready); end
    if (flag !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_flag: got %b want 0", flag); end
    if (busy !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_char();
    logic exp_txd;
    logic exp_flag;
    logic exp_busy;
    bit   ok;
    clear_flag();
    rx_q.delete();
    write_byte(8'h55);
    for (int c = 1; c <= NB * DIV + 3; c++) begin
      @(posedge clk); #1;
      exp_txd  = (c >= 2 && c < 2 + NB * DIV) ? frame_bit(8'h55, (c - 2) / DIV) : 1'b1;
      exp_flag = (c >= 1 + NB * DIV);
      exp_busy = (c < 1 + NB * DIV);
      vectors += 3;
      if (txd !== exp_txd) begin
        miscompares++; $display("[TB] FAIL single_txd c=%0d: got %b want %b", c, txd, exp_txd);
      end
      if (flag !== exp_flag) begin
        miscompares++; $display("[TB] FAIL single_flag c=%0d: got %b want %b", c, flag, exp_flag);
      end
      if (busy !== exp_busy) begin
        miscompares++; $display("[TB] FAIL single_busy c=%0d: got %b want %b", c, busy, exp_busy);
      end
    end
    wait_idle(ok);
    vectors += 2;
    if (!ok) begin miscompares++; $display("[TB] FAIL single_idle: busy stuck high"); end
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      miscompares++; $display("[TB] FAIL single_rx: got %0d bytes, want 1 byte 55", rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic exp_txd;
    logic exp_flag;
    int   idx;
    bit   ok;
    clear_flag();
    rx_q.delete();
    write_byte(8'h80);
    write_byte(8'h01);
    for (int c = 2; c <= 2 * NB * DIV + 3; c++) begin
      @(posedge clk); #1;
      idx = c - 2;
      if (idx < NB * DIV)          exp_txd = frame_bit(8'h80, idx / DIV);
      else if (idx < 2 * NB * DIV) exp_txd = frame_bit(8'h01, (idx - NB * DIV) / DIV);
      else                         exp_txd = 1'b1;
      exp_flag = (c == 1 + NB * DIV) || (c >= 1 + 2 * NB * DIV);
      vectors += 2;
      if (txd !== exp_txd) begin
        miscompares++; $display("[TB] FAIL b2b_txd c=%0d: got %b want %b", c, txd, exp_txd);
      end
      if (flag !== exp_flag) begin
        miscompares++; $display("[TB] FAIL b2b_flag c=%0d: got %b want %b", c, flag, exp_flag);
      end
      flag_clr = (c == 1 + NB * DIV);
    end
    flag_clr = 1'b0;
    wait_idle(ok);
    vectors += 2;
    if (!ok) begin miscompares++; $display("[TB] FAIL b2b_idle: busy stuck high"); end
    if (rx_q.size() != 2 || rx_q[0] !== 8'h80 || rx_q[1] !== 8'h01) begin
      miscompares++; $display("[TB] FAIL b2b_rx: got %0d bytes, want 80 01", rx_q.size());
    end
  endtask

  task automatic test_fill_fifo();
    logic [7:0] b[6];
    logic       exp_ready;
    bit         ok;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    rx_q.delete();
    write_byte(b[0]);
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      exp_ready = ((k - 1) < DEPTH);
      vectors++;
      if (wr_ready !== exp_ready) begin
        miscompares++; $display("[TB] FAIL fill_ready k=%0d: got %b want %b", k, wr_ready, exp_ready);
      end
      write_byte(b[k]);
    end
    vectors++;
    if (wr_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL fill_ready_end: got %b want 0", wr_ready);
    end
    wait_idle(ok);
    vectors += 2;
    if (!ok) begin miscompares++; $display("[TB] FAIL fill_idle: busy stuck high"); end
    if (rx_q.size() != 5) begin
      miscompares++; $display("[TB] FAIL fill_count: got %0d frames want 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (rx_q[i] !== b[i]) begin
          miscompares++; $display("[TB] FAIL fill_byte%0d: got %h want %h", i, rx_q[i], b[i]);
        end
      end
    end
  endtask

  task automatic test_flag_race();
    logic [7:0] b;
    bit         ok;
    b = 8'($urandom);
    clear_flag();
    rx_q.delete();
    write_byte(b);
    repeat (NB * DIV) @(posedge clk);
    #1;
    vectors += 3;
    if (flag !== 1'b0) begin miscompares++; $display("[TB] FAIL race_pre: got %b want 0", flag); end
    flag_clr = 1'b1;
    @(posedge clk); #1;
    if (flag !== 1'b1) begin miscompares++; $display("[TB] FAIL race_set_wins: got %b want 1", flag); end
    @(posedge clk); #1;
    if (flag !== 1'b0) begin miscompares++; $display("[TB] FAIL race_clear: got %b want 0", flag); end
    flag_clr = 1'b0;
    wait_idle(ok);
    vectors += 2;
    if (!ok) begin miscompares++; $display("[TB] FAIL race_idle: busy stuck high"); end
    if (rx_q.size() != 1 || rx_q[0] !== b) begin
      miscompares++; $display("[TB] FAIL race_rx: got %0d bytes, want 1 byte %h", rx_q.size(), b);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    bit         ok;
    int         waited;
    rx_q.delete();
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 50)) @(posedge clk);
      #1;
      waited = 0;
      while (wr_ready !== 1'b1 && waited < 2000) begin
        @(posedge clk); #1;
        waited++;
      end
      vectors++;
      if (waited >= 2000) begin
        miscompares++; $display("[TB] FAIL rand_ready_timeout n=%0d: wr_ready=%b want 1", n, wr_ready);
      end else begin
        b = 8'($urandom);
        exp_q.push_back(b);
        write_byte(b);
      end
    end
    wait_idle(ok);
    vectors += 2;
    if (!ok) begin miscompares++; $display("[TB] FAIL rand_idle: busy stuck high"); end
    if (rx_q.size() != exp_q.size()) begin
      miscompares++; $display("[TB] FAIL rand_count: got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (rx_q[i] !== exp_q[i]) begin
          miscompares++; $display("[TB] FAIL rand_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    bit         ok;
    rx_q.delete();
    write_byte(8'hA5);
    write_byte(8'h3C);
    repeat (3 * DIV + 1) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    vectors += 4;
    if (txd !== 1'b1)      begin miscompares++; $display("[TB] FAIL abort_txd: got %b want 1", txd); end
    if (busy !== 1'b0)     begin miscompares++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    if (wr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_ready: got %b want 1", wr_ready); end
    if (flag !== 1'b0)     begin miscompares++; $display("[TB] FAIL abort_flag: got %b want 0", flag); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (NB * DIV) @(posedge clk);
    #1;
    vectors += 3;
    if (txd !== 1'b1)    begin miscompares++; $display("[TB] FAIL abort_quiet_txd: got %b want 1", txd); end
    if (busy !== 1'b0)   begin miscompares++; $display("[TB] FAIL abort_quiet_busy: got %b want 0", busy); end
    if (rx_q.size() != 0) begin
      miscompares++; $display("[TB] FAIL abort_partial: got %0d frames want 0", rx_q.size());
    end
    b = 8'($urandom);
    write_byte(b);
    wait_idle(ok);
    vectors += 2;
    if (!ok) begin miscompares++; $display("[TB] FAIL abort_idle: busy stuck high"); end
    if (rx_q.size() != 1 || rx_q[0] !== b) begin
      miscompares++; $display("[TB] FAIL abort_rx: got %0d bytes, want 1 byte %h", rx_q.size(), b);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    wr_valid    = 1'b0;
    wr_data     = 8'h00;
    flag_clr    = 1'b0;
    #1;
    test_reset();
    test_single_char();
    test_back_to_back();
    test_fill_fifo();
    test_flag_race();
    test_random();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
